// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// mem_stage: memory-access pipeline stage.
// Accepts one instruction per cycle from execute, performs loads/stores over
// a single-outstanding req/ack bus, formats load data and drives registered
// write-back signals into the register file write port. Holds upstream with
// stall_req while a bus transaction is pending.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned halfword/word
// accesses are rejected with a one-cycle misalign pulse instead of a bus
// access). Undefined by default: misalign is constant 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid/ex_wd/ex_wreg   execute-stage instruction and destination
//   ex_wdata                 ALU result
//   ex_mem_op                0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW,
//                            6 SB, 7 SH, 8 SW, 9-15 none
//   ex_mem_addr              effective byte address
//   ex_store_data            store source value
//   stall_req                hold execute and earlier stages
//   mem_req/we/addr/sel/wdata  data-bus request (word address, lane enables)
//   mem_rdata/mem_ack        data-bus response
//   wb_w_en/addr/data        register file write port
//   misalign                 misaligned-access pulse
module mem_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [4:0]        ex_wd,
  input  logic              ex_wreg,
  input  logic [31:0]       ex_wdata,
  input  logic [3:0]        ex_mem_op,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [31:0]       ex_store_data,
  output logic              stall_req,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_sel,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_w_en,
  output logic [4:0]        wb_w_addr,
  output logic [31:0]       wb_w_data,
  output logic              misalign
);

  typedef enum logic {S_IDLE, S_BUS} state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW
  } op_e;

  state_e              r_state;
  state_e              w_next;

  logic [3:0]          r_op;
  logic [1:0]          r_lane;
  logic [4:0]          r_wd;
  logic                r_wreg;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [3:0]          r_mem_sel;
  logic [31:0]         r_mem_wdata;
  logic                r_wb_en;
  logic [4:0]          r_wb_addr;
  logic [31:0]         r_wb_data;
  logic                r_misalign;

  logic                w_is_mem;
  logic                w_is_store;
  logic                w_misaligned;
  logic                w_accept;
  logic [3:0]          w_sel;
  logic [31:0]         w_store_data;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load_data;

  assign w_is_mem   = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_SW);
  assign w_is_store = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    w_misaligned = 1'b0;
    case (ex_mem_op)
      OP_LH, OP_LHU, OP_SH: w_misaligned = ex_mem_addr[0];
      OP_LW, OP_SW:         w_misaligned = |ex_mem_addr[1:0];
      default:              w_misaligned = 1'b0;
    endcase
  end
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && ex_valid && w_is_mem && !w_misaligned;

  // Lane enables and replicated store data for the incoming op
  always_comb begin
    w_sel        = '0;
    w_store_data = ex_store_data;
    case (ex_mem_op)
      OP_LB, OP_LBU, OP_SB: w_sel = 4'b0001 << ex_mem_addr[1:0];
      OP_LH, OP_LHU, OP_SH: w_sel = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
      OP_LW, OP_SW:         w_sel = 4'b1111;
      default:              w_sel = '0;
    endcase
    case (ex_mem_op)
      OP_SB:   w_store_data = {4{ex_store_data[7:0]}};
      OP_SH:   w_store_data = {2{ex_store_data[15:0]}};
      default: w_store_data = ex_store_data;
    endcase
  end

  // Load formatting uses the op and lane latched at accept time
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_op)
      OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_data = {24'd0, w_byte};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BUS;
      S_BUS:   if (mem_ack)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: combinational output
  always_comb begin
    stall_req = w_accept || ((r_state == S_BUS) && !mem_ack);
  end

  // Registered bus and write-back datapath; wb_w_en and misalign default
  // low each cycle so they only ever pulse for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= '0;
      r_lane      <= '0;
      r_wd        <= '0;
      r_wreg      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_sel   <= '0;
      r_mem_wdata <= '0;
      r_wb_en     <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_wb_en    <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex_valid) begin
            if (w_is_mem) begin
              if (w_misaligned) begin
                r_misalign <= 1'b1;
              end else begin
                r_op        <= ex_mem_op;
                r_lane      <= ex_mem_addr[1:0];
                r_wd        <= ex_wd;
                r_wreg      <= ex_wreg;
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_is_store;
                r_mem_addr  <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
                r_mem_sel   <= w_sel;
                r_mem_wdata <= w_store_data;
              end
            end else begin
              r_wb_en   <= ex_wreg;
              r_wb_addr <= ex_wd;
              r_wb_data <= ex_wdata;
            end
          end
        end
        S_BUS: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
              r_wb_en   <= r_wreg;
              r_wb_addr <= r_wd;
              r_wb_data <= w_load_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_sel   = r_mem_sel;
  assign mem_wdata = r_mem_wdata;
  assign wb_w_en   = r_wb_en;
  assign wb_w_addr = r_wb_addr;
  assign wb_w_data = r_wb_data;
  assign misalign  = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// Testbench for mem_stage: directed scenarios followed by random instruction
// streams. Expected bus requests, write-back pulses and misalign pulses are
// queued at issue time from a byte-addressed memory model; a monitor pops
// and compares them as the DUT presents them. A bus responder with its own
// memory copy answers requests after a chosen delay and injects stray acks
// while no request is pending.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        stall_req;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_w_en;
  logic [4:0]  wb_w_addr;
  logic [31:0] wb_w_data;
  logic        misalign;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .stall_req(stall_req),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_w_en(wb_w_en), .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data),
    .misalign(misalign)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  wb_t         wq[$];
  bus_t        bq[$];
  int          mq[$];
  logic [31:0] mmem[16];   // reference model memory
  logic [31:0] rmem[16];   // responder memory, updated only from bus traffic
  int          ack_delay = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mb(input logic [31:0] a);
    return mmem[a[5:2]][{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic mset(input logic [31:0] a, input logic [7:0] d);
    mmem[a[5:2]][{a[1:0], 3'b000} +: 8] = d;
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    mmem[idx] = v;
    rmem[idx] = v;
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  // Called just after a falling edge; returns just after the falling edge
  // following the edge at which the instruction advanced.
  task automatic issue(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic [31:0] addr,
                       input logic [31:0] sdata, input int dly, input string nm);
    int          sz;
    bit          ld;
    bit          mis;
    logic [31:0] ea;
    logic [31:0] v;
    int          stalls;
    int          exp_stall;
    int          c;
    int          n;
    logic        s;
    bit          tmo;
    bus_t        b;
    wb_t         e;
    sz  = op_size(op);
    ld  = (op >= 4'd1) && (op <= 4'd5);
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if (sz > 1 && (addr % 32'(sz)) != 0) mis = 1'b1;
`endif
    ea = '0;
    v  = '0;
    ack_delay     = dly;
    ex_valid      = 1'b1;
    ex_mem_op     = op;
    ex_wd         = wd;
    ex_wreg       = wreg;
    ex_wdata      = wdata;
    ex_mem_addr   = addr;
    ex_store_data = sdata;
    if (sz > 0 && !mis) begin
      ea      = addr - (addr % 32'(sz));
      b.addr  = addr - (addr % 32'd4);
      b.sel   = 4'(((1 << sz) - 1) << (ea % 32'd4));
      b.we    = !ld;
      b.wdata = (sz == 1) ? sdata[7:0] * 32'h01010101 :
                (sz == 2) ? sdata[15:0] * 32'h00010001 : sdata;
      bq.push_back(b);
      if (ld) begin
        for (int k = 0; k < sz; k++) v = v | (32'(mb(ea + 32'(k))) << (8 * k));
        if (op == 4'd1) v = {{24{v[7]}}, v[7:0]};
        if (op == 4'd3) v = {{16{v[15]}}, v[15:0]};
      end else begin
        for (int k = 0; k < sz; k++) mset(ea + 32'(k), sdata[8*k +: 8]);
      end
    end
    exp_stall = (sz > 0 && !mis) ? dly + 1 : 0;
    stalls = 0;
    n      = 0;
    c      = 0;
    tmo    = 1'b0;
    forever begin
      #4;
      s = stall_req;
      c = cyc;
      @(posedge clk);
      if (!s) break;
      stalls++;
      n++;
      if (n > 60) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (tmo) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: stall_req still high after %0d cycles, required release", nm, n);
    end
    chk({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    if (sz == 0 && wreg) begin
      e.a = wd; e.d = wdata; e.c = c + 1;
      wq.push_back(e);
    end
    if (ld && !mis && wreg) begin
      e.a = wd; e.d = v; e.c = c + 1;
      wq.push_back(e);
    end
    if (mis) mq.push_back(c + 1);
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  // Bus responder
  initial begin : responder
    int         cnt;
    logic [3:0] idx;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (cnt == ack_delay) begin
          mem_ack = 1'b1;
          cnt     = 0;
          idx     = mem_addr[5:2];
          if (mem_we) begin
            for (int l = 0; l < 4; l++)
              if (mem_sel[l]) rmem[idx][8*l +: 8] = mem_wdata[8*l +: 8];
            mem_rdata = $urandom;
          end else begin
            mem_rdata = rmem[idx];
          end
        end else begin
          cnt++;
          mem_rdata = $urandom;
        end
      end else begin
        cnt       = 0;
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    wb_t  e;
    bus_t b;
    logic prev_req;
    logic exp_m;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (wq.size() > 0 && wq[0].c == cyc) begin
        e = wq.pop_front();
        chk("wb_en", 32'(wb_w_en), 32'd1);
        chk("wb_addr", 32'(wb_w_addr), 32'(e.a));
        chk("wb_data", wb_w_data, e.d);
      end else begin
        chk("wb_en_idle", 32'(wb_w_en), 32'd0);
      end
      exp_m = (mq.size() > 0 && mq[0] == cyc);
      if (exp_m) void'(mq.pop_front());
      chk("misalign", 32'(misalign), 32'(exp_m));
      if (mem_req && !prev_req) begin
        if (bq.size() == 0) begin
          chk("bus_unexpected_req", 32'(mem_req), 32'd0);
        end else begin
          b = bq.pop_front();
          chk("mem_addr", mem_addr, b.addr);
          chk("mem_sel", 32'(mem_sel), 32'(b.sel));
          chk("mem_we", 32'(mem_we), 32'(b.we));
          if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
        end
      end
      prev_req = mem_req;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin : main
    bus_t rb;
    rst           = 1'b1;
    ex_valid      = 1'b0;
    ex_wd         = '0;
    ex_wreg       = 1'b0;
    ex_wdata      = '0;
    ex_mem_op     = '0;
    ex_mem_addr   = '0;
    ex_store_data = '0;
    for (int i = 0; i < 16; i++) poke(i, $urandom);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall_req", 32'(stall_req), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_sel", 32'(mem_sel), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_w_en", 32'(wb_w_en), 32'd0);
    chk("rst_wb_w_addr", 32'(wb_w_addr), 32'd0);
    chk("rst_wb_w_data", wb_w_data, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    rst = 1'b0;

    issue(4'd0, 5'd3, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 0, "alu");
    poke(0, 32'h80AA5511);
    issue(4'd1, 5'd5, 1'b1, 32'h0, 32'h103, 32'h0, 3, "lb");
    issue(4'd2, 5'd6, 1'b1, 32'h0, 32'h103, 32'h0, 3, "lbu");
    issue(4'd7, 5'd1, 1'b1, 32'h0, 32'h202, 32'h1234ABCD, 0, "sh");
    poke(4, 32'h0000CAFE);
    issue(4'd5, 5'd9, 1'b1, 32'h0, 32'h10, 32'h0, 1, "lw");
    issue(4'd0, 5'd10, 1'b1, 32'h13572468, 32'h0, 32'h0, 0, "alu_after_lw");

    // Reset two cycles into a bus transaction that is never acknowledged
    ack_delay     = 1000;
    ex_valid      = 1'b1;
    ex_mem_op     = 4'd5;
    ex_mem_addr   = 32'h20;
    ex_wd         = 5'd7;
    ex_wreg       = 1'b1;
    rb.addr = 32'h20; rb.sel = 4'hF; rb.we = 1'b0; rb.wdata = '0;
    bq.push_back(rb);
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_wb_w_en", 32'(wb_w_en), 32'd0);
    chk("abort_stall_req", 32'(stall_req), 32'd0);
    ack_delay = 0;
    issue(4'd0, 5'd12, 1'b1, 32'hA5A5F00D, 32'h0, 32'h0, 0, "alu_after_abort");

    issue(4'd5, 5'd11, 1'b1, 32'h0, 32'h6, 32'h0, 1, "lw_unaligned");
    issue(4'd12, 5'd13, 1'b1, 32'h0BADF00D, 32'h4, 32'h0, 0, "op12_as_none");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ex_valid  = 1'b0;
        ex_mem_op = 4'($urandom_range(0, 15));
        ex_wd     = 5'($urandom_range(0, 31));
        ex_wdata  = $urandom;
        @(negedge clk);
      end
      issue(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), "rnd");
    end

    repeat (4) @(negedge clk);
    chk("wb_queue_drained", 32'(wq.size()), 32'd0);
    chk("bus_queue_drained", 32'(bq.size()), 32'd0);
    chk("misalign_queue_drained", 32'(mq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-level pipeline. It sits between the execute stage and the register file write port. It accepts one instruction per cycle from execute and performs loads and stores over a single-outstanding request/ack data bus. It formats load data and drives registered write-back signals straight into the register file's write port (`w_en`/`w_addr`/`w_data`). While a bus transaction is pending it holds the upstream pipeline with `stall_req`.

## Interface
Parameters:
- `ADDR_W`, default 32: data-bus address width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  execute-stage instruction present.
- `ex_wd`  in  5  destination register.
- `ex_wreg`  in  1  instruction writes a register.
- `ex_wdata`  in  32  ALU result.
- `ex_mem_op`  in  4  operation code:
  - 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW.
  - 9–15 are treated as none.
- `ex_mem_addr`  in  ADDR_W  effective byte address.
- `ex_store_data`  in  32  store source register value.
- `stall_req`  out  1  hold execute and earlier stages.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 = store.
- `mem_addr`  out  ADDR_W  word address `{addr[ADDR_W-1:2],2'b00}`.
- `mem_sel`  out  4  byte-lane enables.
- `mem_wdata`  out  32  store data.
- `mem_rdata`  in  32  load data, valid with `mem_ack`.
- `mem_ack`  in  1  transaction complete.
- `wb_w_en`  out  1  to register file `w_en`.
- `wb_w_addr`  out  5  to register file `w_addr`.
- `wb_w_data`  out  32  to register file `w_data`.
- `misalign`  out  1  misaligned-access pulse; tied 0 unless the macro is defined.

## Operation
FSM states:
- **IDLE**
  - A non-memory op with `ex_valid=1` is registered to the `wb_*` outputs at the next edge:
    - `wb_w_en = ex_wreg`
    - `wb_w_addr = ex_wd`
    - `wb_w_data = ex_wdata`
  - A memory op latches the operation code, address, lane, store data and destination, then goes to BUS.
  - `ex_valid=0` produces a bubble: `wb_w_en=0` next cycle.
- **BUS**
  - `mem_req=1` is held, and all `mem_*` outputs are held from registers.
  - Upstream inputs are ignored.
  - On `mem_ack=1`:
    - Loads register `wb_w_en=ex_wreg`, `wb_w_addr`, and the formatted data.
    - Stores register `wb_w_en=0`.
    - The FSM returns to IDLE.
- Lane selection, with lane = `addr[1:0]`:
  - Byte ops: `mem_sel = 4'b0001<<lane`.
  - Halfword ops: `mem_sel = addr[1] ? 4'b1100 : 4'b0011`.
  - Word ops: `mem_sel = 4'b1111`.
- Store data is replicated across lanes:
  - SB: `{4{data[7:0]}}`.
  - SH: `{2{data[15:0]}}`.
  - SW: as-is.
- Load formatting:
  - LB/LH sign-extend the selected byte/halfword.
  - LBU/LHU zero-extend it.
  - LW passes `mem_rdata` through.
- Register 0 is not special-cased here; the register file discards writes to it.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0: `stall_req`, `mem_req`, `mem_we`, `mem_addr`, `mem_sel`, `mem_wdata`, `wb_w_en`, `wb_w_addr`, `wb_w_data`, `misalign`.
- `stall_req` (combinational) = `(IDLE & ex_valid & mem_op_is_mem & ~misaligned) | (BUS & ~mem_ack)`.
- Upstream must hold its `ex_*` inputs stable while `stall_req=1`. It advances at the edge where `stall_req=0`, including the `mem_ack` cycle.
- Non-memory latency: 1 cycle.
- Memory latency:
  - Accepted at T0; `mem_req` is high from T1.
  - With ack at Tn (n≥1), `wb_*` is valid at Tn+1. The minimum is 2 cycles.
- `wb_w_en` is a single-cycle pulse per instruction. It is 0 in every cycle where no result completes.
- `mem_ack` outside BUS is ignored.
- `rst` asserted in BUS:
  - The next edge drops `mem_req`, returns to IDLE and clears outputs.
  - The aborted transaction produces no write-back.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - In IDLE, an access is misaligned if it is LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]≠0`.
  - A misaligned access:
    - issues no bus request and raises no stall;
    - produces `misalign=1` for one cycle at the next edge, with `wb_w_en=0`;
    - leaves the FSM in IDLE.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `misalign` is constant 0.
  - Low address bits not used for lane selection are ignored: halfword uses `addr[1]` only; word ignores `addr[1:0]`.

## Test plan
- ALU op `ex_wd=3`, `ex_wreg=1`, `ex_wdata=32'hDEADBEEF` → next cycle `wb_w_en=1`, `wb_w_addr=3`, `wb_w_data=32'hDEADBEEF`, `stall_req` never high.
- LB at address `32'h103`, `mem_rdata=32'h80AA5511`, ack 3 cycles after `mem_req` rises:
  - `mem_sel=4'b1000` and `stall_req` high for 4 cycles.
  - `wb_w_data=32'hFFFFFF80` one cycle after ack.
  - Repeat as LBU → `32'h00000080`.
- SH at address `32'h202`, `ex_store_data=32'h1234ABCD`, immediate ack → `mem_we=1`, `mem_sel=4'b1100`, `mem_wdata=32'hABCDABCD`, `mem_addr=32'h200`, `wb_w_en=0`.
- Back-to-back LW at `0x10` then ALU op, with `mem_rdata=32'h0000CAFE` → two consecutive write-back pulses in program order. The ALU op is not lost or duplicated across the ack edge.
- `rst` asserted 2 cycles into BUS, ack never given → next cycle `mem_req=0`, `wb_w_en=0`, `stall_req=0`. The following ALU op completes normally.
- With `MEM_ALIGN_CHECK_EN`, LW at `32'h6` → `misalign=1` for 1 cycle, `mem_req` stays 0, `wb_w_en=0`. Without the macro → bus access at `mem_addr=32'h4` with `mem_sel=4'b1111`.
